// File: rtl/jtag_master.sv
`default_nettype none
//==============================================================================
// Module      : jtag_master
// Description : Host-side JTAG driver. Runs TLR, IR scan, DR scan and idle
//               clock commands from Run-Test/Idle back to Run-Test/Idle.
// Revision    : 1.0 - initial release
//==============================================================================
module jtag_master #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);

    localparam int CNT_W = LEN_W + 1;
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [1:0] c_OP_TLR  = 2'b00;
    localparam logic [1:0] c_OP_IR   = 2'b01;
    localparam logic [1:0] c_OP_DR   = 2'b10;
    localparam logic [1:0] c_OP_IDLE = 2'b11;

    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic             tms;
        logic             shift;
        logic [IDX_W-1:0] idx;
    } bit_t;

    // Describes TCK bit j of a command: its TMS level and, for shift bits,
    // which data/capture position it carries.
    function automatic bit_t bit_info(input logic [1:0]       op,
                                      input logic [CNT_W-1:0] n,
                                      input logic [CNT_W-1:0] j);
        bit_t             b;
        logic [CNT_W-1:0] pre;
        logic [CNT_W-1:0] i;
        b   = '0;
        pre = (op == c_OP_IR) ? CNT_W'(4) : CNT_W'(3);
        i   = j - pre;
        case (op)
            c_OP_TLR: b.tms = (j < CNT_W'(5));
            c_OP_IR, c_OP_DR: begin
                if (j < pre) begin
                    b.tms = (op == c_OP_IR) ? (j < CNT_W'(2)) : (j == '0);
                end else if (i < n) begin
                    b.shift = 1'b1;
                    b.tms   = (i == n - CNT_W'(1));
                    b.idx   = i[IDX_W-1:0];
                end else begin
                    b.tms = (i == n);
                end
            end
            default: b.tms = 1'b0;
        endcase
        return b;
    endfunction

    function automatic logic [CNT_W-1:0] eff_len(input logic [1:0]       op,
                                                 input logic [LEN_W-1:0] len);
        logic [CNT_W-1:0] l;
        l = {1'b0, len};
        if (op == c_OP_IDLE)          return l;
        if (l == '0)                  return CNT_W'(1);
        if (l > CNT_W'(MAX_LEN))      return CNT_W'(MAX_LEN);
        return l;
    endfunction

    function automatic logic [CNT_W-1:0] seq_len(input logic [1:0]       op,
                                                 input logic [CNT_W-1:0] n);
        case (op)
            c_OP_TLR: return CNT_W'(6);
            c_OP_IR:  return n + CNT_W'(6);
            c_OP_DR:  return n + CNT_W'(5);
            default:  return n;
        endcase
    endfunction

    state_t             r_state_q, r_state_d;
    logic [1:0]         r_op_q,    r_op_d;
    logic [CNT_W-1:0]   r_n_q,     r_n_d;
    logic [CNT_W-1:0]   r_k_q,     r_k_d;
    logic [CNT_W-1:0]   r_j_q,     r_j_d;
    logic [DIV_W-1:0]   r_div_q,   r_div_d;
    logic [MAX_LEN-1:0] r_data_q,  r_data_d;
    logic [MAX_LEN-1:0] r_cap_q,   r_cap_d;
    logic [MAX_LEN-1:0] r_rsp_q,   r_rsp_d;
    logic               r_tck_q,   r_tck_d;
    logic               r_tms_q,   r_tms_d;
    logic               r_tdi_q,   r_tdi_d;

    logic               w_accept;
    logic [CNT_W-1:0]   w_new_n;
    logic [CNT_W-1:0]   w_new_k;
    bit_t               w_first;
    bit_t               w_cur;
    bit_t               w_nxt;

    assign cmd_ready = (r_state_q != ST_RUN);
    assign rsp_valid = (r_state_q == ST_DONE);
    assign rsp_data  = r_rsp_q;
    assign tck       = r_tck_q;
    assign tms       = r_tms_q;
    assign tdi       = r_tdi_q;

    assign w_accept = cmd_valid && cmd_ready;
    assign w_new_n  = eff_len(cmd_op, cmd_len);
    assign w_new_k  = seq_len(cmd_op, w_new_n);
    assign w_first  = bit_info(cmd_op, w_new_n, '0);
    assign w_cur    = bit_info(r_op_q, r_n_q, r_j_q);
    assign w_nxt    = bit_info(r_op_q, r_n_q, r_j_q + CNT_W'(1));

    always_comb begin
        r_state_d = r_state_q;
        r_op_d    = r_op_q;
        r_n_d     = r_n_q;
        r_k_d     = r_k_q;
        r_j_d     = r_j_q;
        r_div_d   = r_div_q;
        r_data_d  = r_data_q;
        r_cap_d   = r_cap_q;
        r_rsp_d   = r_rsp_q;
        r_tck_d   = r_tck_q;
        r_tms_d   = r_tms_q;
        r_tdi_d   = r_tdi_q;

        case (r_state_q)
            ST_RUN: begin
                r_div_d = r_div_q + DIV_W'(1);
                if (r_div_q == c_DIV_LAST) begin
                    r_div_d = '0;
                    r_tck_d = ~r_tck_q;
                    if (!r_tck_q) begin
                        if (w_cur.shift) begin
                            r_cap_d[w_cur.idx] = tdo;
                        end
                    end else if (r_j_q == r_k_q - CNT_W'(1)) begin
                        r_state_d = ST_DONE;
                        r_tms_d   = 1'b0;
                        r_tdi_d   = 1'b0;
                        r_rsp_d   = r_cap_q;
                    end else begin
                        r_j_d   = r_j_q + CNT_W'(1);
                        r_tms_d = w_nxt.tms;
                        r_tdi_d = w_nxt.shift & r_data_q[w_nxt.idx];
                    end
                end
            end
            default: begin
                r_state_d = ST_IDLE;
                if (w_accept) begin
                    r_op_d   = cmd_op;
                    r_n_d    = w_new_n;
                    r_k_d    = w_new_k;
                    r_data_d = cmd_data;
                    r_j_d    = '0;
                    r_div_d  = '0;
                    r_tck_d  = 1'b0;
                    r_cap_d  = '0;
                    r_tms_d  = w_first.tms;
                    r_tdi_d  = w_first.shift & cmd_data[w_first.idx];
                    r_state_d = ST_RUN;
                    // Zero-length idle completes without any TCK activity.
                    if (w_new_k == '0) begin
                        r_state_d = ST_DONE;
                        r_tms_d   = 1'b0;
                        r_tdi_d   = 1'b0;
                        r_rsp_d   = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_op_q    <= '0;
            r_n_q     <= '0;
            r_k_q     <= '0;
            r_j_q     <= '0;
            r_div_q   <= '0;
            r_data_q  <= '0;
            r_cap_q   <= '0;
            r_rsp_q   <= '0;
            r_tck_q   <= 1'b0;
            r_tms_q   <= 1'b1;
            r_tdi_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_op_q    <= r_op_d;
            r_n_q     <= r_n_d;
            r_k_q     <= r_k_d;
            r_j_q     <= r_j_d;
            r_div_q   <= r_div_d;
            r_data_q  <= r_data_d;
            r_cap_q   <= r_cap_d;
            r_rsp_q   <= r_rsp_d;
            r_tck_q   <= r_tck_d;
            r_tms_q   <= r_tms_d;
            r_tdi_q   <= r_tdi_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_master.sv
`default_nettype none
//==============================================================================
// Module      : tb_jtag_master
// Description : Scoreboard bench for jtag_master with a behavioural TAP target.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_jtag_master;

    localparam int          CLK_DIV    = 2;
    localparam int          MAX_LEN    = 32;
    localparam int          LEN_W      = 6;
    localparam logic [31:0] IR_CAPTURE = 32'h1;
    localparam logic [31:0] IR_RESET   = 32'h1;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [LEN_W-1:0]   cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               tck, tms, tdi, tdo;

    jtag_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1);
    end

    // ---------------- behavioural TAP target (IEEE 1149.1 state graph)
    typedef enum int {
        S_TLR, S_RTI, S_SELDR, S_CAPDR, S_SHDR, S_EX1DR, S_PAUDR, S_EX2DR, S_UPDR,
        S_SELIR, S_CAPIR, S_SHIR, S_EX1IR, S_PAUIR, S_EX2IR, S_UPIR
    } tap_e;

    tap_e        tap    = S_TLR;
    logic [31:0] tap_dr = 32'h0;
    logic [31:0] tap_ir = IR_RESET;
    logic [63:0] cap_sr = 64'h0;
    logic [63:0] shin   = 64'h0;
    logic [5:0]  sh_cnt = 6'd0;

    assign tdo = (tap == S_SHDR || tap == S_SHIR) ? cap_sr[sh_cnt] : 1'b0;

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            S_TLR:   return m ? S_TLR   : S_RTI;
            S_RTI:   return m ? S_SELDR : S_RTI;
            S_SELDR: return m ? S_SELIR : S_CAPDR;
            S_CAPDR: return m ? S_EX1DR : S_SHDR;
            S_SHDR:  return m ? S_EX1DR : S_SHDR;
            S_EX1DR: return m ? S_UPDR  : S_PAUDR;
            S_PAUDR: return m ? S_EX2DR : S_PAUDR;
            S_EX2DR: return m ? S_UPDR  : S_SHDR;
            S_UPDR:  return m ? S_SELDR : S_RTI;
            S_SELIR: return m ? S_TLR   : S_CAPIR;
            S_CAPIR: return m ? S_EX1IR : S_SHIR;
            S_SHIR:  return m ? S_EX1IR : S_SHIR;
            S_EX1IR: return m ? S_UPIR  : S_PAUIR;
            S_PAUIR: return m ? S_EX2IR : S_PAUIR;
            S_EX2IR: return m ? S_UPIR  : S_SHIR;
            default: return m ? S_SELDR : S_RTI;
        endcase
    endfunction

    // One rising TCK edge as seen by the target; registers are as long as
    // the scan that updates them.
    task automatic tap_step(input logic m, input logic d);
        case (tap)
            S_CAPDR: begin cap_sr = {32'h0, tap_dr};     sh_cnt = 6'd0; shin = 64'h0; end
            S_CAPIR: begin cap_sr = {32'h0, IR_CAPTURE}; sh_cnt = 6'd0; shin = 64'h0; end
            S_SHDR, S_SHIR: begin
                shin[sh_cnt] = d;
                if (sh_cnt != 6'd63) sh_cnt = sh_cnt + 6'd1;
            end
            S_UPDR: tap_dr = shin[31:0];
            S_UPIR: tap_ir = shin[31:0];
            default: ;
        endcase
        tap = tap_next(tap, m);
        if (tap == S_TLR) begin
            tap_ir = IR_RESET;
            tap_dr = 32'h0;
        end
    endtask

    // ---------------- scoreboard
    typedef struct {
        logic [1:0]  op;
        int          k;
        logic [63:0] tmsv;
        logic [31:0] rsp;
        logic [31:0] reg_exp;
        int          acc;
        bit          b2b;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_dr = 32'h0;
    logic [31:0] exp_ir = IR_RESET;
    bit          tb_done = 1'b0;

    function automatic logic [31:0] mask32(input int n);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        return m[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] len,
                         input logic [31:0] data, input bit b2b);
        exp_t e;
        int   n, p, t;
        n = int'(len);
        if (op != 2'b11) begin
            if (n == 0) n = 1;
            if (n > MAX_LEN) n = MAX_LEN;
        end
        e.tmsv = 64'h0;
        p = 0;
        case (op)
            2'b00: begin
                for (int i = 0; i < 5; i++) begin e.tmsv[p] = 1'b1; p++; end
                p++;
            end
            2'b01, 2'b10: begin
                e.tmsv[p] = 1'b1; p++;
                if (op == 2'b01) begin e.tmsv[p] = 1'b1; p++; end
                p += 2;
                for (int i = 0; i < n; i++) begin e.tmsv[p] = (i == n - 1); p++; end
                e.tmsv[p] = 1'b1; p += 2;
            end
            default: p = n;
        endcase
        e.op  = op;
        e.k   = p;
        e.b2b = b2b;
        case (op)
            2'b00: begin e.rsp = 32'h0; exp_ir = IR_RESET; exp_dr = 32'h0; e.reg_exp = exp_dr; end
            2'b01: begin e.rsp = IR_CAPTURE & mask32(n); exp_ir = data & mask32(n); e.reg_exp = exp_ir; end
            2'b10: begin e.rsp = exp_dr & mask32(n); exp_dr = data & mask32(n); e.reg_exp = exp_dr; end
            default: begin e.rsp = 32'h0; e.reg_exp = 32'h0; end
        endcase
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        t = 0;
        while (!cmd_ready && t < 2000) begin tick(); t++; end
        if (cmd_ready) begin
            e.acc = cyc;
            sb.push_back(e);
            tick();
        end
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_len   = 6'($urandom);
        cmd_data  = $urandom;
    endtask

    // ---------------- stimulus
    initial begin
        logic [1:0] rop;
        logic [5:0] rlen;
        int         w;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = '0; cmd_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        issue(2'b00, 6'd0, 32'h0, 1'b0);
        issue(2'b10, 6'd32, 32'h0000003C, 1'b0);
        issue(2'b10, 6'd8, 32'h000000A5, 1'b0);
        repeat (5) tick();
        if (!cmd_ready) begin
            cmd_valid = 1'b1; cmd_op = 2'b11; cmd_len = 6'd0;
            tick();
            cmd_valid = 1'b0;
        end
        issue(2'b10, 6'd32, 32'h0, 1'b0);
        issue(2'b01, 6'd4, 32'hE, 1'b0);
        issue(2'b10, 6'd32, 32'hDEADBEEF, 1'b0);
        issue(2'b10, 6'd32, 32'h12345678, 1'b1);
        issue(2'b10, 6'd32, 32'h0, 1'b0);
        issue(2'b11, 6'd0, 32'hFFFFFFFF, 1'b0);
        issue(2'b10, 6'd0, 32'h00000003, 1'b0);
        issue(2'b10, 6'd40, 32'hCAFEF00D, 1'b0);
        issue(2'b10, 6'd32, 32'h0, 1'b0);
        issue(2'b10, 6'd32, $urandom, 1'b0);
        repeat (40) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        issue(2'b00, 6'd0, 32'h0, 1'b0);
        issue(2'b10, 6'd16, 32'h0000BEEF, 1'b0);
        issue(2'b10, 6'd16, 32'h0, 1'b0);
        for (int r = 0; r < 40; r++) begin
            rop = 2'($urandom_range(0, 3));
            case (rop)
                2'b01:   rlen = 6'($urandom_range(1, 8));
                2'b10:   rlen = 6'($urandom_range(0, 40));
                2'b11:   rlen = 6'($urandom_range(0, 12));
                default: rlen = 6'($urandom);
            endcase
            w = $urandom_range(0, 3);
            repeat (w) tick();
            issue(rop, rlen, $urandom, 1'b0);
        end
        w = 0;
        while (sb.size() != 0 && w < 3000) begin tick(); w++; end
        tb_done = 1'b1;
    end

    // ---------------- monitor / checker
    int          checks = 0;
    int          failures = 0;
    int          pulses = 0;
    int          tim_err = 0;
    int          hold_err = 0;
    int          last_rsp_cyc = -1;
    logic [63:0] obs_tms = 64'h0;
    logic [31:0] last_rsp = 32'h0;
    logic        prev_tck = 1'b0;
    logic        prev_rst = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
            pulses = 0; tim_err = 0; hold_err = 0; obs_tms = 64'h0;
            prev_tck = 1'b0; last_rsp = 32'h0; prev_rst = 1'b1;
        end else begin
            if (prev_rst) begin
                chk("reset_pins", {60'h0, tck, tms, tdi, cmd_ready}, 64'h5);
                chk("reset_rsp", {31'h0, rsp_valid, rsp_data}, 64'h0);
                prev_rst = 1'b0;
            end
            if (tck && !prev_tck) begin
                if (pulses < 64) obs_tms[pulses] = tms;
                if (sb.size() > 0 && cyc != sb[0].acc + 1 + CLK_DIV + 2 * pulses * CLK_DIV)
                    tim_err++;
                pulses++;
                tap_step(tms, tdi);
            end else if (!tck && prev_tck) begin
                if (sb.size() > 0 && cyc != sb[0].acc + 1 + 2 * pulses * CLK_DIV)
                    tim_err++;
            end
            prev_tck = tck;
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_data", {32'h0, rsp_data}, {32'h0, e.rsp});
                    chk("tck_pulses", 64'(pulses), 64'(e.k));
                    chk("tms_seq", obs_tms & ((64'd1 << e.k) - 64'd1), e.tmsv);
                    chk("latency", 64'(cyc), 64'(e.acc + 1 + 2 * e.k * CLK_DIV));
                    chk("tck_timing", 64'(tim_err), 64'd0);
                    chk("rsp_hold", 64'(hold_err), 64'd0);
                    chk("tap_in_rti", 64'(tap == S_RTI), 64'd1);
                    if (e.op == 2'b01) chk("ir_update", {32'h0, tap_ir}, {32'h0, e.reg_exp});
                    if (e.op == 2'b10 || e.op == 2'b00)
                        chk("dr_update", {32'h0, tap_dr}, {32'h0, e.reg_exp});
                    if (e.b2b) chk("b2b_accept", 64'(e.acc), 64'(last_rsp_cyc));
                    last_rsp = e.rsp;
                end
                last_rsp_cyc = cyc;
                pulses = 0; tim_err = 0; hold_err = 0; obs_tms = 64'h0;
            end else if (rsp_data !== last_rsp) begin
                hold_err++;
            end
            if (sb.size() > 0 && cyc - sb[0].acc > 2000) begin
                chk("completion_timeout", 64'd1, 64'd0);
                void'(sb.pop_front());
                pulses = 0; tim_err = 0; hold_err = 0; obs_tms = 64'h0;
            end
            if (tb_done) begin
                chk("scoreboard_drained", 64'(sb.size()), 64'd0);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/jtag_master.md
Name: jtag_master

Overview:
- Host-side JTAG driver. It generates TCK/TMS/TDI and captures TDO to operate the on-chip JTAG TAP (test logic) from the other end of the scan interface.
- It sits between a simple command/response interface and the TAP pins. It executes TAP reset, IR scan, DR scan and idle-clock commands.
- It tracks TAP state implicitly: every command starts and ends in Run-Test/Idle.

Parameters:
- CLK_DIV, 2, clk cycles per TCK half-period (>=1).
- MAX_LEN, 32, maximum scan length in bits and width of data paths.
- LEN_W, 6, width of cmd_len (must hold MAX_LEN).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master idle, can accept a command.
- cmd_op  in  2  00=TLR reset, 01=IR scan, 10=DR scan, 11=idle clocks.
- cmd_len  in  LEN_W  scan length, or idle TCK count.
- cmd_data  in  MAX_LEN  TDI bits, LSB shifted first.
- rsp_valid  out  1  one-cycle pulse at command completion.
- rsp_data  out  MAX_LEN  captured TDO bits, first captured bit in [0].
- tck  out  1  JTAG clock.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data to target.
- tdo  in  1  JTAG data from target.

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=1, rsp_valid=0, rsp_data=0.
- Reset mid-command aborts the command immediately. No rsp_valid is issued. TAP state is then unknown, and the host must issue TLR.
- States: IDLE, RUN, DONE.
- Command acceptance:
  - A command is accepted on the edge where cmd_valid && cmd_ready. cmd_ready drops the next cycle.
  - cmd_op, cmd_len and cmd_data are latched at acceptance; later input changes are ignored.
- Bit sequences. Each command is a sequence of K TCK bits (tms, tdi, capture flag):
  - TLR: TMS 1,1,1,1,1,0; K=6; ends in Run-Test/Idle.
  - IR scan, length N: TMS 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR), then N shift bits with TMS=0 except the last with TMS=1, then TMS 1,0. K=N+6.
  - DR scan, length N: TMS 1,0,0, then the N shift bits as for IR, then 1,0. K=N+5.
  - Idle: N bits of TMS=0; K=N.
  - tdi = cmd_data[i] on shift bit i; tdi=0 on all non-shift bits.
- Length clamping:
  - For scans, cmd_len=0 is treated as 1, and cmd_len>MAX_LEN is clamped to MAX_LEN.
  - Idle with cmd_len=0: K=0, no TCK edges; rsp_valid pulses in the cycle after acceptance.
- Timing, with E0 the acceptance edge:
  - Bit 0 tms/tdi are driven from E0.
  - tck rises at E0+CLK_DIV and falls at E0+2·CLK_DIV.
  - Bit j is driven from E0+2j·CLK_DIV, so tms/tdi change only on the edge where tck falls (or at E0).
  - tck high and low phases are each exactly CLK_DIV clk cycles.
- TDO capture:
  - tdo is sampled on the clk edge where tck goes 0→1, during shift bits only.
  - Shift bit i is stored in rsp_data[i]. Bits [MAX_LEN-1:N] are 0.
  - TLR and idle commands return rsp_data=0.
- Completion:
  - At edge E0+2K·CLK_DIV (the final tck fall), the master enters DONE.
  - rsp_valid is high for exactly one cycle, and cmd_ready is high in that same cycle. A back-to-back command may be accepted then.
  - rsp_data holds its value until the next completion.
- Idle line state: tck=0 and tms=0 (TAP parked in Run-Test/Idle), except after reset, where tms=1.
- A cmd_valid with cmd_ready=0 is not accepted and not queued.

Test Plan:
1. Reset, then TLR, CLK_DIV=2 → exactly 6 tck pulses with TMS 1,1,1,1,1,0. rsp_valid pulses 24 cycles after acceptance with rsp_data=0. The TAP model reaches Run-Test/Idle.
2. DR scan, len=8, cmd_data=0xA5, against a TAP model whose DR holds 0x3C → 13 tck pulses. TDI during shift is LSB-first 1,0,1,0,0,1,0,1. rsp_data=0x0000003C. The TAP DR updates to 0xA5.
3. IR scan, len=4, data=0xE, IR capture value 0x1 → TMS sequence 1,1,0,0,0,0,0,1,1,0. rsp_data=0x1. TAP IR=0xE.
4. DR scan, len=32, data=0xDEADBEEF, immediately followed by a second command accepted in the rsp_valid cycle → both complete. The second begins with no idle gap. First rsp_data equals the prior DR contents.
5. Edge cases: idle with len=0 → rsp_valid 1 cycle after acceptance, no tck edges. DR scan with len=0 → behaves as len=1. DR scan with len=40 → clamped to 32 shift bits.
6. reset asserted midway through a DR scan → the next cycle shows tck=0, tms=1, cmd_ready=1, and no rsp_valid. A following TLR plus DR scan completes correctly.
